// File: rtl/serial_adder_ctrl.sv
// Nibble-serial WIDTH-bit add/subtract controller built around one 4-bit
// carry-lookahead slice, with valid/ready handshakes on request and result.

module m_adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is flattened from generate/propagate terms, so no carry
  // depends on a lower carry.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk_1,
  input  logic             i_rst_1,
  input  logic             i_valid_1,
  output logic             o_ready_1,
  input  logic             i_sub_1,
  input  logic [WIDTH-1:0] i_operand1_32,
  input  logic [WIDTH-1:0] i_operand2_32,
  output logic             o_valid_1,
  input  logic             i_ready_1,
  output logic [WIDTH-1:0] o_result_32,
  output logic             o_cOut_1,
  output logic             o_overflow_1,
  output logic             o_zero_1
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             ovf;
  logic             zero;

  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_sum;
  logic             nib_cout;
  logic             last_nib;

  assign nib_a    = op_a[{cnt, 2'b00} +: 4];
  assign nib_b    = op_b[{cnt, 2'b00} +: 4];
  assign last_nib = (cnt == LAST);

  m_adder4 u_slice (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // NOTE: the default assignment before the conditional write keeps this
  // block purely combinational; without it a latch would be inferred.
  always_comb begin
    acc_next = acc;
    acc_next[{cnt, 2'b00} +: 4] = nib_sum;
  end

  // Control and visible result state.
  always_ff @(posedge i_clk_1) begin
    if (i_rst_1) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      result <= '0;
      c_out  <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid_1) begin
            carry <= i_sub_1;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          carry <= nib_cout;
          if (last_nib) begin
            cnt    <= '0;
            result <= acc_next;
            zero   <= (acc_next == '0);
            c_out  <= nib_cout;
            ovf    <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &
                      (nib_sum[3] != op_a[WIDTH-1]);
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (i_ready_1) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // NOTE: operand and partial-sum registers carry no reset; every nibble is
  // rewritten by a capture or a RUN cycle before anything observable uses it.
  always_ff @(posedge i_clk_1) begin
    if (state == IDLE && i_valid_1) begin
      op_a <= i_operand1_32;
      op_b <= i_sub_1 ? ~i_operand2_32 : i_operand2_32;
    end
    if (state == RUN) begin
      acc <= acc_next;
    end
  end

  assign o_ready_1    = (state == IDLE);
  assign o_valid_1    = (state == DONE);
  assign o_result_32  = result;
  assign o_cOut_1     = c_out;
  assign o_overflow_1 = ovf;
  assign o_zero_1     = zero;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH = 32).

module tb_serial_adder_ctrl;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic        i_sub;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_cout;
  logic        o_ovf;
  logic        o_zero;

  int checks = 0;
  int errors = 0;

  serial_adder_ctrl #(.WIDTH(32)) dut (
    .i_clk_1       (clk),
    .i_rst_1       (rst),
    .i_valid_1     (i_valid),
    .o_ready_1     (o_ready),
    .i_sub_1       (i_sub),
    .i_operand1_32 (op1),
    .i_operand2_32 (op2),
    .o_valid_1     (o_valid),
    .i_ready_1     (i_ready),
    .o_result_32   (o_result),
    .o_cOut_1      (o_cout),
    .o_overflow_1  (o_ovf),
    .o_zero_1      (o_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, verify the ready drop and the 8-cycle latency, then the
  // result fields. With rdy=1 the result handshake is also verified.
  task automatic run_op(input string tag, input logic sub, input logic [31:0] a,
                        input logic [31:0] b, input logic rdy,
                        input logic [31:0] exp_res, input logic exp_c,
                        input logic exp_v, input logic exp_z);
    int n;
    i_sub   = sub;
    op1     = a;
    op2     = b;
    i_ready = rdy;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    check({tag, " ready_low"}, {31'd0, o_ready}, 32'd0);
    n = 0;
    while (!o_valid && n < 30) begin
      step();
      n++;
    end
    check({tag, " latency"}, n, 32'd8);
    check({tag, " result"}, o_result, exp_res);
    check({tag, " cout"}, {31'd0, o_cout}, {31'd0, exp_c});
    check({tag, " ovf"}, {31'd0, o_ovf}, {31'd0, exp_v});
    check({tag, " zero"}, {31'd0, o_zero}, {31'd0, exp_z});
    if (rdy) begin
      step();
      check({tag, " handshake"}, {30'd0, o_valid, o_ready}, 32'b01);
    end
  endtask

  initial begin
    int t[3];
    int cnt;
    int n;
    logic saw_valid;
    logic saw_busy;

    rst = 1'b1; i_valid = 1'b0; i_sub = 1'b0; op1 = '0; op2 = '0; i_ready = 1'b0;
    step();
    step();
    check("reset ready/valid", {30'd0, o_valid, o_ready}, 32'b01);
    check("reset result", o_result, 32'd0);
    check("reset flags", {29'd0, o_cout, o_ovf, o_zero}, 32'd0);
    rst = 1'b0;
    step();

    run_op("add1+1", 1'b0, 32'h0000_0001, 32'h0000_0001, 1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    run_op("addripple", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op("addovf", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_op("sub5-7", 1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op("subovf", 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

    // Back-pressure: result held while the consumer stalls.
    run_op("bp", 1'b1, 32'h1234_5678, 32'h0234_5670, 1'b0, 32'h1000_0008, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      i_valid = ~i_valid;
      i_sub   = ~i_sub;
      op1     = $urandom;
      op2     = $urandom;
      step();
      check("bp hold result", o_result, 32'h1000_0008);
      check("bp hold flags", {29'd0, o_cout, o_ovf, o_zero}, 32'b100);
      check("bp hold valid/ready", {30'd0, o_valid, o_ready}, 32'b10);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    step();
    check("bp release", {30'd0, o_valid, o_ready}, 32'b01);
    check("bp persist result", o_result, 32'h1000_0008);
    step();
    check("bp no capture", {30'd0, o_valid, o_ready}, 32'b01);

    // Reset during RUN nibble 3, concurrent with a request.
    i_sub = 1'b0; op1 = 32'h0F0F_0F0F; op2 = 32'h0101_0101; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    i_valid = 1'b1;
    step();
    rst = 1'b0;
    i_valid = 1'b0;
    check("midrst ready/valid", {30'd0, o_valid, o_ready}, 32'b01);
    check("midrst result", o_result, 32'd0);
    check("midrst flags", {29'd0, o_cout, o_ovf, o_zero}, 32'd0);
    saw_valid = 1'b0;
    saw_busy  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      saw_valid |= o_valid;
      saw_busy  |= ~o_ready;
    end
    check("midrst no valid pulse", {31'd0, saw_valid}, 32'd0);
    check("midrst no capture", {31'd0, saw_busy}, 32'd0);

    run_op("add3+4", 1'b0, 32'd3, 32'd4, 1'b1, 32'd7, 1'b0, 1'b0, 1'b0);

    // Back-to-back requests with the consumer always ready.
    i_sub = 1'b0; op1 = 32'd10; op2 = 32'd20; i_ready = 1'b1; i_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 3; i++) begin
      @(negedge clk);
      if (o_ready) begin
        t[cnt] = i;
        cnt++;
      end
      @(posedge clk);
    end
    #1;
    i_valid = 1'b0;
    check("b2b accepts", cnt, 32'd3);
    check("b2b gap1", t[1] - t[0], 32'd10);
    check("b2b gap2", t[2] - t[1], 32'd10);
    n = 0;
    while (!o_valid && n < 30) begin
      step();
      n++;
    end
    check("b2b last latency", n, 32'd8);
    check("b2b result", o_result, 32'h0000_001E);
    step();
    check("b2b final handshake", {30'd0, o_valid, o_ready}, 32'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
